seg16_msg_loader: RTL

//  Receive end of the 16-segment scrolling display: accepts an ASCII message byte-by-byte over a

---
 rtl/seg16_msg_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seg16_msg_loader.sv
// Stream-loaded message buffer that scrolls ASCII text across a two-digit
// active-low 16-segment display (LEDa left, LEDb right).
module seg16_msg_loader #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned STEP_DIV = 22,
  parameter int unsigned GAP      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear,
  output logic        busy,
  output logic [6:0]  msg_len,
  output logic [15:0] LEDa,
  output logic [15:0] LEDb
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_L = 7'(DEPTH);
  localparam logic [1:0]  GAP_L   = 2'(GAP);
  localparam logic [15:0] BLANK   = 16'hFFFF;

  // Active-high segment masks; glyphs are stored inverted (active-low).
  localparam logic [15:0] SEG_A  = 16'hC000;
  localparam logic [15:0] SEG_B  = 16'h2000;
  localparam logic [15:0] SEG_C  = 16'h1000;
  localparam logic [15:0] SEG_D  = 16'h0C00;
  localparam logic [15:0] SEG_E  = 16'h0200;
  localparam logic [15:0] SEG_F  = 16'h0100;
  localparam logic [15:0] SEG_G1 = 16'h0080;
  localparam logic [15:0] SEG_G2 = 16'h0040;
  localparam logic [15:0] SEG_H  = 16'h0020;
  localparam logic [15:0] SEG_I  = 16'h0010;
  localparam logic [15:0] SEG_J  = 16'h0008;
  localparam logic [15:0] SEG_K  = 16'h0004;
  localparam logic [15:0] SEG_L  = 16'h0002;
  localparam logic [15:0] SEG_M  = 16'h0001;
  localparam logic [15:0] SEG_G  = SEG_G1 | SEG_G2;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_SCROLL = 1'b1
  } state_t;

  state_t               state, state_d;
  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        rd_ptr, rd_ptr_d;
  logic [1:0]           gap_cnt, gap_cnt_d;
  logic [STEP_DIV-1:0]  presc, presc_d;
  logic [6:0]           msg_len_d;
  logic                 char_ready_d, busy_d, wr_en;
  logic [15:0]          led_a_d, led_b_d;

  logic                 is_nl, xfer, tick, last_char;
  logic [7:0]           rd_char;

  // Font lookup; lowercase folds to uppercase, unmapped codes are blank.
  function automatic logic [15:0] glyph(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A":     glyph = 16'h0C3F;
      "B":     glyph = 16'h033F;
      "C":     glyph = 16'h30FF;
      "D":     glyph = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_I | SEG_L);
      "E":     glyph = ~(SEG_A | SEG_D | SEG_E | SEG_F | SEG_G);
      "F":     glyph = ~(SEG_A | SEG_E | SEG_F | SEG_G1);
      "G":     glyph = ~(SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G2);
      "H":     glyph = 16'hCC3F;
      "I":     glyph = ~(SEG_A | SEG_D | SEG_I | SEG_L);
      "J":     glyph = ~(SEG_B | SEG_C | SEG_D | SEG_E);
      "K":     glyph = ~(SEG_E | SEG_F | SEG_G1 | SEG_J | SEG_M);
      "L":     glyph = ~(SEG_D | SEG_E | SEG_F);
      "M":     glyph = 16'hCCD7;
      "N":     glyph = ~(SEG_B | SEG_C | SEG_E | SEG_F | SEG_H | SEG_M);
      "O":     glyph = 16'h00FF;
      "P":     glyph = 16'h1C3F;
      "Q":     glyph = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_M);
      "R":     glyph = ~(SEG_A | SEG_B | SEG_E | SEG_F | SEG_G | SEG_M);
      "S":     glyph = ~(SEG_A | SEG_C | SEG_D | SEG_F | SEG_G);
      "T":     glyph = ~(SEG_A | SEG_I | SEG_L);
      "U":     glyph = ~(SEG_B | SEG_C | SEG_D | SEG_E | SEG_F);
      "V":     glyph = ~(SEG_E | SEG_F | SEG_J | SEG_K);
      "W":     glyph = ~(SEG_B | SEG_C | SEG_E | SEG_F | SEG_K | SEG_M);
      "X":     glyph = ~(SEG_H | SEG_J | SEG_K | SEG_M);
      "Y":     glyph = 16'hFFD5;
      "Z":     glyph = ~(SEG_A | SEG_D | SEG_J | SEG_K);
      "0":     glyph = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_J | SEG_K);
      "1":     glyph = ~(SEG_B | SEG_C | SEG_J);
      "2":     glyph = ~(SEG_A | SEG_B | SEG_D | SEG_E | SEG_G);
      "3":     glyph = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_G2);
      "4":     glyph = ~(SEG_B | SEG_C | SEG_F | SEG_G);
      "5":     glyph = ~(SEG_A | SEG_C | SEG_D | SEG_F | SEG_G);
      "6":     glyph = ~(SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G);
      "7":     glyph = ~(SEG_A | SEG_B | SEG_C);
      "8":     glyph = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G);
      "9":     glyph = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G);
      default: glyph = BLANK;
    endcase
  endfunction

  assign is_nl     = (char_in == 8'h0A);
  assign xfer      = (state == ST_LOAD) & char_valid & char_ready & ~clear;
  assign tick      = &presc;
  assign last_char = (7'(rd_ptr) == (msg_len - 7'd1));
  assign rd_char   = mem[rd_ptr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_d;
  end

  // Next state: newline commits a non-empty message, a full buffer auto-commits.
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = ST_LOAD;
    end else if (xfer) begin
      if (is_nl) begin
        if (msg_len != 7'd0) state_d = ST_SCROLL;
      end else if (msg_len == DEPTH_L - 7'd1) begin
        state_d = ST_SCROLL;
      end
    end
  end

  // Next values of registered outputs and scroll datapath.
  always_comb begin
    msg_len_d = msg_len;
    rd_ptr_d  = rd_ptr;
    gap_cnt_d = gap_cnt;
    presc_d   = presc;
    led_a_d   = LEDa;
    led_b_d   = LEDb;
    wr_en     = 1'b0;

    if (clear || state == ST_LOAD) begin
      rd_ptr_d  = '0;
      gap_cnt_d = '0;
      presc_d   = '0;
      led_a_d   = BLANK;
      led_b_d   = BLANK;
      if (clear) begin
        msg_len_d = '0;
      end else if (xfer && !is_nl) begin
        wr_en     = 1'b1;
        msg_len_d = msg_len + 7'd1;
      end
    end else begin
      presc_d = presc + STEP_DIV'(1);
      if (tick) begin
        led_a_d = LEDb;
        if (gap_cnt != 2'd0) begin
          led_b_d   = BLANK;
          gap_cnt_d = gap_cnt - 2'd1;
        end else begin
          led_b_d = glyph(rd_char);
          if (last_char) begin
            rd_ptr_d  = '0;
            gap_cnt_d = GAP_L;
          end else begin
            rd_ptr_d  = rd_ptr + AW'(1);
          end
        end
      end
    end

    busy_d       = (state_d == ST_SCROLL);
    char_ready_d = (state_d == ST_LOAD) && !clear && (msg_len_d < DEPTH_L);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len    <= '0;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      presc      <= '0;
      LEDa       <= BLANK;
      LEDb       <= BLANK;
      busy       <= 1'b0;
      char_ready <= 1'b1;
    end else begin
      msg_len    <= msg_len_d;
      rd_ptr     <= rd_ptr_d;
      gap_cnt    <= gap_cnt_d;
      presc      <= presc_d;
      LEDa       <= led_a_d;
      LEDb       <= led_b_d;
      busy       <= busy_d;
      char_ready <= char_ready_d;
    end
  end

  // Message storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[msg_len[AW-1:0]] <= char_in;
  end

endmodule
